// File: rtl/led_pwm_axil.sv
// NUM_CH LED channels (off/on/pwm/one-shot) behind an AXI4-Lite register file; led_o is registered.
// Each access takes one ready pulse then a response beat; a pending BVALID/RVALID blocks the next accept.
module led_pwm_axil #(
  parameter int NUM_CH             = 2,
  parameter int CNT_W              = 16,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            clk100,
  input  logic                            rstn,
  input  logic [63:0]                     git_hash,
  input  logic [31:0]                     timestamp,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_CH-1:0]               led_o
);

  logic              aw_rdy, b_vld, ar_rdy, r_vld;
  logic [31:0]       r_dat;
  logic              wr_fire, rd_fire;
  logic [5:0]        wa, ra;
  logic [31:0]       rd_word;
  logic [NUM_CH-1:0] ctrl_we, period_we, duty_we;

  logic [1:0]        mode     [NUM_CH];
  logic [CNT_W-1:0]  period   [NUM_CH];
  logic [CNT_W-1:0]  duty     [NUM_CH];
  logic [CNT_W-1:0]  period_s [NUM_CH];
  logic [CNT_W-1:0]  duty_s   [NUM_CH];
  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [NUM_CH-1:0] done, led_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  assign wa      = S_AXI_AWADDR[7:2];
  assign ra      = S_AXI_ARADDR[7:2];
  assign wr_fire = aw_rdy && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire = ar_rdy && S_AXI_ARVALID;

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY  = aw_rdy;
  assign S_AXI_BVALID  = b_vld;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID  = r_vld;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = r_dat;
  assign led_o         = led_q;

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      aw_rdy <= 1'b0;
      b_vld  <= 1'b0;
      ar_rdy <= 1'b0;
      r_vld  <= 1'b0;
      r_dat  <= '0;
    end else begin
      // Ready is a one-cycle pulse; the response beat that follows holds off the next accept.
      aw_rdy <= !aw_rdy && !b_vld && S_AXI_AWVALID && S_AXI_WVALID;
      if (wr_fire)           b_vld <= 1'b1;
      else if (S_AXI_BREADY) b_vld <= 1'b0;
      ar_rdy <= !ar_rdy && !r_vld && S_AXI_ARVALID;
      if (rd_fire) begin
        r_vld <= 1'b1;
        r_dat <= rd_word;
      end else if (S_AXI_RREADY) begin
        r_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    ctrl_we   = '0;
    period_we = '0;
    duty_we   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_fire && wa[5:2] == 4'(i + 2)) begin
        case (wa[1:0])
          2'd0:    ctrl_we[i]   = 1'b1;
          2'd1:    period_we[i] = 1'b1;
          2'd2:    duty_we[i]   = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (ra)
      6'h0:    rd_word = git_hash[31:0];
      6'h1:    rd_word = git_hash[63:32];
      6'h2:    rd_word = timestamp;
      6'h3:    rd_word = {24'h0, 8'(NUM_CH)};
      default: ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (ra[5:2] == 4'(i + 2)) begin
        case (ra[1:0])
          2'd0: rd_word = {30'h0, mode[i]};
          2'd1: rd_word = 32'(period[i]);
          2'd2: rd_word = 32'(duty[i]);
          default: begin
            rd_word     = 32'(cnt[i]);
            rd_word[31] = done[i];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode[i]     <= '0;
        period[i]   <= '0;
        duty[i]     <= '0;
        period_s[i] <= '0;
        duty_s[i]   <= '0;
        cnt[i]      <= '0;
      end
      done  <= '0;
      led_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (period_we[i]) period[i] <= CNT_W'(merge_be(32'(period[i]), S_AXI_WDATA, S_AXI_WSTRB));
        if (duty_we[i])   duty[i]   <= CNT_W'(merge_be(32'(duty[i]), S_AXI_WDATA, S_AXI_WSTRB));

        case (mode[i])
          2'd0:    led_q[i] <= 1'b0;
          2'd1:    led_q[i] <= 1'b1;
          default: led_q[i] <= cnt[i] < duty_s[i];
        endcase

        // A CTRL write restarts the channel and outranks a same-cycle pwm wrap.
        if (ctrl_we[i]) begin
          if (S_AXI_WSTRB[0]) mode[i] <= S_AXI_WDATA[1:0];
          cnt[i]      <= '0;
          done[i]     <= 1'b0;
          period_s[i] <= period[i];
          duty_s[i]   <= duty[i];
        end else begin
          case (mode[i])
            2'd2: begin
              if (cnt[i] == period_s[i]) begin
                cnt[i]      <= '0;
                period_s[i] <= period[i];
                duty_s[i]   <= duty[i];
              end else begin
                cnt[i] <= cnt[i] + CNT_W'(1);
              end
            end
            2'd3: begin
              if (cnt[i] == duty_s[i]) done[i] <= 1'b1;
              else                     cnt[i]  <= cnt[i] + CNT_W'(1);
            end
            default: cnt[i] <= '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_axil.sv
// Bench for led_pwm_axil: randomized register traffic and LED waveforms checked against
// closed-form expectations (pwm phase arithmetic, one-shot pulse length, register image).
module tb_led_pwm_axil;
  localparam int NUM_CH = 2;
  localparam logic [63:0] HASH = 64'h0123_4567_89AB_CDEF;
  localparam logic [31:0] TS   = 32'h6600_1234;

  logic        clk100 = 1'b0;
  logic        rstn = 1'b1;
  logic [63:0] git_hash = HASH;
  logic [31:0] timestamp = TS;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [NUM_CH-1:0] led_o;

  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [31:0] m_ctrl [NUM_CH], m_period [NUM_CH], m_duty [NUM_CH];

  led_pwm_axil #(.NUM_CH(NUM_CH), .CNT_W(16)) dut (
    .clk100(clk100), .rstn(rstn), .git_hash(git_hash), .timestamp(timestamp),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .led_o(led_o)
  );

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // fire = index of the clock edge on which the write was accepted (-1 on timeout)
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output int fire, output logic [1:0] resp);
    int t;
    fire = -1; resp = 2'bxx;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1; bready = 1;
    t = 0;
    @(negedge clk100);
    while (!awready && t < 20) begin @(negedge clk100); t++; end
    if (!awready) begin
      n_cmp++; n_err++;
      $display("FAIL aw_timeout addr=%h awready=%b required=1", addr, awready);
      awvalid = 0; wvalid = 0;
      return;
    end
    fire = cyc + 1;
    @(posedge clk100); #1;
    awvalid = 0; wvalid = 0;
    t = 0;
    @(negedge clk100);
    while (!bvalid && t < 20) begin @(negedge clk100); t++; end
    if (!bvalid) begin
      n_cmp++; n_err++;
      $display("FAIL b_timeout addr=%h bvalid=%b required=1", addr, bvalid);
      return;
    end
    resp = bresp;
    @(posedge clk100); #1;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int t;
    data = 'x; resp = 2'bxx;
    araddr = addr; arvalid = 1; rready = 1;
    t = 0;
    @(negedge clk100);
    while (!arready && t < 20) begin @(negedge clk100); t++; end
    if (!arready) begin
      n_cmp++; n_err++;
      $display("FAIL ar_timeout addr=%h arready=%b required=1", addr, arready);
      arvalid = 0;
      return;
    end
    @(posedge clk100); #1;
    arvalid = 0;
    t = 0;
    @(negedge clk100);
    while (!rvalid && t < 20) begin @(negedge clk100); t++; end
    if (!rvalid) begin
      n_cmp++; n_err++;
      $display("FAIL r_timeout addr=%h rvalid=%b required=1", addr, rvalid);
      return;
    end
    data = rdata; resp = rresp;
    @(posedge clk100); #1;
  endtask

  function automatic logic [31:0] ro_value(input logic [7:0] addr);
    case (addr)
      8'h00:   return HASH[31:0];
      8'h04:   return HASH[63:32];
      8'h08:   return TS;
      8'h0C:   return 32'(NUM_CH);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_reg(input int ch, input int sel);
    if (sel == 0) return m_ctrl[ch];
    if (sel == 1) return m_period[ch];
    return m_duty[ch];
  endfunction

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    #3 rstn = 0;
    repeat (3) @(negedge clk100);
    n_cmp++;
    if ({awready, wready, bvalid, arready, rvalid, bresp, rresp} !== 9'h0) begin
      n_err++; $display("FAIL reset_handshake got=%b required=0", {awready, wready, bvalid, arready, rvalid, bresp, rresp});
    end
    n_cmp++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h required=0", rdata); end
    n_cmp++;
    if (led_o !== '0) begin n_err++; $display("FAIL reset_led got=%b required=0", led_o); end
    rstn = 1;
    for (int i = 0; i < NUM_CH; i++) begin m_ctrl[i] = 0; m_period[i] = 0; m_duty[i] = 0; end
    repeat (2) @(negedge clk100);
    for (int a = 0; a < 16; a += 4) begin
      axi_read(8'(a), d, r);
      n_cmp++;
      if (d !== ro_value(8'(a)) || r !== 2'b00) begin
        n_err++; $display("FAIL id_read addr=%h got=%h/%b required=%h/00", a, d, r, ro_value(8'(a)));
      end
    end
    n_cmp++;
    if (led_o !== '0) begin n_err++; $display("FAIL post_reset_led got=%b required=0", led_o); end
  endtask

  task automatic test_regs();
    int f, ch, sel; logic [1:0] r; logic [31:0] d, data, nv; logic [3:0] strb; logic [7:0] addr;
    logic [7:0] unm [6];
    unm = '{8'h00, 8'h0C, 8'h10, 8'h1C, 8'h40, 8'hF0};
    for (int it = 0; it < 24; it++) begin
      ch = $urandom_range(NUM_CH - 1, 0); sel = $urandom_range(2, 0);
      addr = 8'h20 + 8'(16 * ch) + 8'(4 * sel);
      data = $urandom; strb = 4'($urandom);
      nv = model_reg(ch, sel);
      for (int b = 0; b < 4; b++) if (strb[b]) nv[8*b +: 8] = data[8*b +: 8];
      nv = nv & ((sel == 0) ? 32'h3 : 32'hFFFF);
      if (sel == 0) m_ctrl[ch] = nv; else if (sel == 1) m_period[ch] = nv; else m_duty[ch] = nv;
      axi_write(addr, data, strb, f, r);
      n_cmp++;
      if (r !== 2'b00) begin n_err++; $display("FAIL rw_bresp addr=%h got=%b required=00", addr, r); end
      axi_read(addr, d, r);
      n_cmp++;
      if (d !== nv || r !== 2'b00) begin
        n_err++; $display("FAIL rw_readback addr=%h strb=%h got=%h/%b required=%h/00", addr, strb, d, r, nv);
      end
    end
    foreach (unm[j]) begin
      axi_write(unm[j], $urandom, 4'hF, f, r);
      n_cmp++;
      if (r !== 2'b00) begin n_err++; $display("FAIL unmapped_bresp addr=%h got=%b required=00", unm[j], r); end
      axi_read(unm[j], d, r);
      n_cmp++;
      if (d !== ro_value(unm[j])) begin
        n_err++; $display("FAIL unmapped_read addr=%h got=%h required=%h", unm[j], d, ro_value(unm[j]));
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < 3; s++) begin
        axi_read(8'h20 + 8'(16 * c) + 8'(4 * s), d, r);
        n_cmp++;
        if (d !== model_reg(c, s)) begin
          n_err++; $display("FAIL regs_intact ch=%0d sel=%0d got=%h required=%h", c, s, d, model_reg(c, s));
        end
      end
    end
  endtask

  task automatic test_wstrb();
    int f; logic [1:0] r; logic [31:0] d;
    axi_write(8'h28, 32'h0, 4'hF, f, r);
    axi_write(8'h28, 32'hFFFF_FFAA, 4'b0001, f, r);
    m_duty[0] = 32'hAA;
    axi_read(8'h28, d, r);
    n_cmp++;
    if (d !== 32'h0000_00AA) begin n_err++; $display("FAIL wstrb_duty got=%h required=000000aa", d); end
    axi_write(8'h1C, 32'h1234_5678, 4'hF, f, r);
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL unmapped_1c_bresp got=%b required=00", r); end
    axi_read(8'h28, d, r);
    n_cmp++;
    if (d !== 32'h0000_00AA) begin n_err++; $display("FAIL wstrb_after_1c got=%h required=000000aa", d); end
  endtask

  task automatic test_pwm();
    int f, p, d, k; logic [1:0] r; logic e;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin p = 9; d = 3; end
      else begin p = $urandom_range(12, 0); d = $urandom_range(p + 2, 0); end
      axi_write(8'h24, 32'(p), 4'hF, f, r);
      axi_write(8'h28, 32'(d), 4'hF, f, r);
      axi_write(8'h20, 32'd2, 4'hF, f, r);
      m_period[0] = 32'(p); m_duty[0] = 32'(d); m_ctrl[0] = 2;
      if (f < 0) continue;
      for (int n = 0; n < 5 * (p + 1); n++) begin
        @(negedge clk100);
        k = cyc - f - 1;
        e = (k % (p + 1)) < d;
        n_cmp++;
        if (led_o[0] !== e) begin
          n_err++; $display("FAIL pwm_led p=%0d d=%0d k=%0d got=%b required=%b", p, d, k, led_o[0], e);
        end
      end
    end
  endtask

  task automatic test_period_change();
    int f0, f1, kw, s_sw, p, p2, d, k, pre; logic [1:0] r; logic e;
    for (int it = 0; it < 2; it++) begin
      p = 9; d = 3;
      p2  = (it == 0) ? 4 : $urandom_range(7, 1);
      pre = (it == 0) ? 3 : $urandom_range(15, 0);
      axi_write(8'h24, 32'(p), 4'hF, f0, r);
      axi_write(8'h28, 32'(d), 4'hF, f0, r);
      axi_write(8'h20, 32'd2, 4'hF, f0, r);
      for (int n = 0; n < pre; n++) begin
        @(negedge clk100);
        k = cyc - f0 - 1;
        e = (k % (p + 1)) < d;
        n_cmp++;
        if (led_o[0] !== e) begin n_err++; $display("FAIL pchg_pre k=%0d got=%b required=%b", k, led_o[0], e); end
      end
      axi_write(8'h24, 32'(p2), 4'hF, f1, r);
      m_period[0] = 32'(p2); m_duty[0] = 32'(d); m_ctrl[0] = 2;
      if (f0 < 0 || f1 < 0) continue;
      // The PERIOD register is only sampled at a wrap, so the new length starts at the next period boundary.
      kw = f1 - f0 - 1;
      s_sw = ((kw + 2 + p) / (p + 1)) * (p + 1);
      for (int n = 0; n < (s_sw - kw) + 4 * (p2 + 1); n++) begin
        @(negedge clk100);
        k = cyc - f0 - 1;
        e = (k < s_sw) ? ((k % (p + 1)) < d) : (((k - s_sw) % (p2 + 1)) < d);
        n_cmp++;
        if (led_o[0] !== e) begin
          n_err++; $display("FAIL pchg_led p2=%0d k=%0d switch=%0d got=%b required=%b", p2, k, s_sw, led_o[0], e);
        end
      end
    end
  endtask

  task automatic test_oneshot();
    int f, d, k; logic [1:0] r; logic [31:0] st; logic e;
    for (int it = 0; it < 3; it++) begin
      d = (it == 0) ? 5 : (it == 1) ? 0 : $urandom_range(9, 1);
      axi_write(8'h38, 32'(d), 4'hF, f, r);
      m_duty[1] = 32'(d); m_ctrl[1] = 3;
      for (int rep = 0; rep < 2; rep++) begin
        axi_write(8'h30, 32'd3, 4'hF, f, r);
        if (f < 0) continue;
        for (int n = 0; n < d + 4; n++) begin
          @(negedge clk100);
          k = cyc - f - 1;
          e = k < d;
          n_cmp++;
          if (led_o[1] !== e) begin
            n_err++; $display("FAIL oneshot_led d=%0d rep=%0d k=%0d got=%b required=%b", d, rep, k, led_o[1], e);
          end
        end
        axi_read(8'h3C, st, r);
        n_cmp++;
        if (st !== (32'h8000_0000 | 32'(d))) begin
          n_err++; $display("FAIL oneshot_status d=%0d got=%h required=%h", d, st, 32'h8000_0000 | 32'(d));
        end
      end
    end
    axi_write(8'h30, 32'd1, 4'hF, f, r);
    repeat (2) @(negedge clk100);
    n_cmp++;
    if (led_o[1] !== 1'b1) begin n_err++; $display("FAIL mode_on got=%b required=1", led_o[1]); end
    axi_read(8'h3C, st, r);
    n_cmp++;
    if (st !== 32'h0) begin n_err++; $display("FAIL status_after_ctrl got=%h required=0", st); end
    axi_write(8'h30, 32'd0, 4'hF, f, r);
    m_ctrl[1] = 0;
    repeat (2) @(negedge clk100);
    n_cmp++;
    if (led_o[1] !== 1'b0) begin n_err++; $display("FAIL mode_off got=%b required=0", led_o[1]); end
  endtask

  task automatic test_back_to_back();
    int t; logic [1:0] r; logic [31:0] d;
    bready = 0;
    awaddr = 8'h34; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    t = 0;
    @(negedge clk100);
    while (!awready && t < 20) begin @(negedge clk100); t++; end
    n_cmp++;
    if (!awready) begin n_err++; $display("FAIL b2b_first_aw awready=%b required=1", awready); end
    @(posedge clk100); #1;
    awaddr = 8'h38; wdata = 32'h0055;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk100);
      n_cmp++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        n_err++; $display("FAIL b2b_hold n=%0d bvalid/awready got=%b%b required=10", n, bvalid, awready);
      end
    end
    bready = 1;
    @(negedge clk100);
    n_cmp++;
    if (bvalid !== 1'b0 || awready !== 1'b0) begin
      n_err++; $display("FAIL b2b_release bvalid/awready got=%b%b required=00", bvalid, awready);
    end
    t = 0;
    while (!awready && t < 20) begin @(negedge clk100); t++; end
    n_cmp++;
    if (!awready) begin n_err++; $display("FAIL b2b_second_aw awready=%b required=1", awready); end
    @(posedge clk100); #1;
    awvalid = 0; wvalid = 0;
    t = 0;
    @(negedge clk100);
    while (!bvalid && t < 20) begin @(negedge clk100); t++; end
    @(posedge clk100); #1;
    m_period[1] = 32'h1234; m_duty[1] = 32'h55;
    axi_read(8'h34, d, r);
    n_cmp++;
    if (d !== 32'h1234) begin n_err++; $display("FAIL b2b_period got=%h required=1234", d); end
    axi_read(8'h38, d, r);
    n_cmp++;
    if (d !== 32'h55) begin n_err++; $display("FAIL b2b_duty got=%h required=55", d); end
  endtask

  task automatic test_reset_mid();
    int f, t; logic [1:0] r; logic [31:0] d;
    axi_write(8'h24, 32'd9, 4'hF, f, r);
    axi_write(8'h28, 32'd9, 4'hF, f, r);
    axi_write(8'h20, 32'd2, 4'hF, f, r);
    t = 0;
    @(negedge clk100);
    while (!led_o[0] && t < 30) begin @(negedge clk100); t++; end
    n_cmp++;
    if (!led_o[0]) begin n_err++; $display("FAIL rstmid_led_high got=0 required=1"); end
    @(posedge clk100); #2;
    rstn = 0;
    #1;
    n_cmp++;
    if (led_o !== '0 || {awready, bvalid, arready, rvalid} !== 4'h0) begin
      n_err++; $display("FAIL rstmid_async led=%b hs=%b required=0/0", led_o, {awready, bvalid, arready, rvalid});
    end
    @(negedge clk100);
    rstn = 1;
    for (int i = 0; i < NUM_CH; i++) begin m_ctrl[i] = 0; m_period[i] = 0; m_duty[i] = 0; end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < 4; s++) begin
        axi_read(8'h20 + 8'(16 * c) + 8'(4 * s), d, r);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL rstmid_reg ch=%0d off=%0d got=%h required=0", c, 4 * s, d); end
      end
    end
    n_cmp++;
    if (led_o !== '0) begin n_err++; $display("FAIL rstmid_led_after got=%b required=0", led_o); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_wstrb();
    test_pwm();
    test_period_change();
    test_oneshot();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
